// File: rtl/vga_pkg.sv
// Shared definitions for the rectangle-fill engine.
//
// Contents:
//   fill_state_e      master-port FSM states
//   REG_*_IDX         register word indices (byte offset >> 2)
//   TILE_W / TILE_H   size of the pixel tile painted by one master write
//   x_t / y_t         raster coordinate types, one bit wider than the
//                     field they hold so that end points never wrap

package vga_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } fill_state_e;

    // Word indices decoded from paddr[4:2]
    localparam logic [2:0] REG_CTRL_IDX   = 3'd0;  // byte offset 0x00
    localparam logic [2:0] REG_STATUS_IDX = 3'd1;  // byte offset 0x04
    localparam logic [2:0] REG_ORIGIN_IDX = 3'd2;  // byte offset 0x08
    localparam logic [2:0] REG_SIZE_IDX   = 3'd3;  // byte offset 0x0C
    localparam logic [2:0] REG_COLOR_IDX  = 3'd4;  // byte offset 0x10

    localparam int TILE_W = 6;
    localparam int TILE_H = 3;

    typedef logic [10:0] x_t;
    typedef logic [9:0]  y_t;

endpackage

// File: rtl/vga_fill_regs.sv
// APB slave register file of the rectangle-fill engine.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   s_paddr .. s_pwdata          APB slave request (paddr[4:2] decoded)
//   s_prdata                     combinational read data
//   busy                         engine is running a job (locks job registers)
//   set_done, set_err            one-cycle status set pulses from the engine
//   clr_status                   one-cycle pulse clearing done/err at job start
//   start_pulse                  CTRL.start written while idle
//   x0, y0, fill_w, fill_h       rectangle origin and size
//   color                        12-bit fill colour
//   irq                          done & CTRL.ie

module vga_fill_regs
    import vga_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_paddr,
    input  logic        s_psel,
    input  logic        s_penable,
    input  logic        s_pwrite,
    input  logic [31:0] s_pwdata,
    output logic [31:0] s_prdata,
    input  logic        busy,
    input  logic        set_done,
    input  logic        set_err,
    input  logic        clr_status,
    output logic        start_pulse,
    output logic [9:0]  x0,
    output logic [8:0]  y0,
    output logic [9:0]  fill_w,
    output logic [8:0]  fill_h,
    output logic [11:0] color,
    output logic        irq
);

    logic       wr_en;
    logic [2:0] idx;
    logic       ie;
    logic       done;
    logic       err;

    // Address bits outside the decoded window and unused data bits
    wire unused_bits = ^{s_paddr[31:5], s_paddr[1:0], s_pwdata[31:25], s_pwdata[15:12]};

    assign wr_en = s_psel && s_penable && s_pwrite;
    assign idx   = s_paddr[4:2];

    // Start is a pulse, not a stored bit; it is dropped while a job runs.
    assign start_pulse = wr_en && (idx == REG_CTRL_IDX) && s_pwdata[0] && !busy;

    assign irq = done && ie;

    // Configuration registers: job parameters are frozen while busy so the
    // running raster never sees its bounds move underneath it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ie     <= 1'b0;
            x0     <= '0;
            y0     <= '0;
            fill_w <= '0;
            fill_h <= '0;
            color  <= '0;
        end else if (wr_en) begin
            if (idx == REG_CTRL_IDX) begin
                ie <= s_pwdata[1];
            end
            if (!busy) begin
                case (idx)
                    REG_ORIGIN_IDX: begin
                        x0 <= s_pwdata[9:0];
                        y0 <= s_pwdata[24:16];
                    end
                    REG_SIZE_IDX: begin
                        fill_w <= s_pwdata[9:0];
                        fill_h <= s_pwdata[24:16];
                    end
                    REG_COLOR_IDX: begin
                        color <= s_pwdata[11:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sticky status bits: an engine set beats a same-cycle W1C.
    always_ff @(posedge clock) begin
        if (reset) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (set_done) begin
                done <= 1'b1;
            end else if (clr_status) begin
                done <= 1'b0;
            end else if (wr_en && (idx == REG_STATUS_IDX) && s_pwdata[1]) begin
                done <= 1'b0;
            end

            if (set_err) begin
                err <= 1'b1;
            end else if (clr_status) begin
                err <= 1'b0;
            end else if (wr_en && (idx == REG_STATUS_IDX) && s_pwdata[2]) begin
                err <= 1'b0;
            end
        end
    end

    // Read mux; unmapped offsets read as zero.
    always_comb begin
        s_prdata = '0;
        case (idx)
            REG_CTRL_IDX:   s_prdata = {30'b0, ie, 1'b0};
            REG_STATUS_IDX: s_prdata = {29'b0, err, done, busy};
            REG_ORIGIN_IDX: s_prdata = {7'b0, y0, 6'b0, x0};
            REG_SIZE_IDX:   s_prdata = {7'b0, fill_h, 6'b0, fill_w};
            REG_COLOR_IDX:  s_prdata = {20'b0, color};
            default:        s_prdata = '0;
        endcase
    end

endmodule

// File: rtl/vga_fill_dma.sv
// Rectangle-fill engine in front of the VGA framebuffer.
//
// Software programs origin, size and colour through the APB slave port and
// pulses CTRL.start; the engine then walks the clipped rectangle in 6x3
// tiles, issuing one APB master write per tile into the framebuffer window.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   s_*                   APB slave (register access)
//   m_*                   APB master (tile writes into the framebuffer)
//   irq                   STATUS.done & CTRL.ie

module vga_fill_dma
    import vga_pkg::*;
#(
    parameter logic [31:0] FB_BASE = 32'h2100_0000,
    parameter int          X_MAX   = 640,
    parameter int          Y_MAX   = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s_paddr,
    input  logic        s_psel,
    input  logic        s_penable,
    input  logic        s_pwrite,
    input  logic [31:0] s_pwdata,
    output logic        s_pready,
    output logic [31:0] s_prdata,
    output logic        s_pslverr,
    output logic [31:0] m_paddr,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    input  logic        m_pready,
    input  logic        m_pslverr,
    output logic        irq
);

    localparam x_t X_LIM = x_t'(X_MAX);
    localparam x_t Y_LIM = x_t'(Y_MAX);

    fill_state_e state;
    fill_state_e state_next;

    logic        busy;
    logic        start_pulse;
    logic        start_go;
    logic        set_done;
    logic        set_err;
    logic        clr_status;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  fill_w;
    logic [8:0]  fill_h;
    logic [11:0] color;

    x_t   x;
    y_t   y;
    x_t   x_sum;
    x_t   y_sum;
    x_t   x_end;
    x_t   y_clip;
    y_t   y_end;
    x_t   x_next;
    y_t   y_next;
    logic empty;
    logic row_wrap;
    logic last_tile;
    logic xfer_done;

    // y_end never exceeds Y_MAX, so the top bit of the clipped sum is spare
    wire unused_bits = y_clip[10];

    assign s_pready  = 1'b1;
    assign s_pslverr = 1'b0;
    assign m_pwrite  = 1'b1;
    assign m_pstrb   = 4'hF;

    vga_fill_regs u_regs (
        .clock       (clock),
        .reset       (reset),
        .s_paddr     (s_paddr),
        .s_psel      (s_psel),
        .s_penable   (s_penable),
        .s_pwrite    (s_pwrite),
        .s_pwdata    (s_pwdata),
        .s_prdata    (s_prdata),
        .busy        (busy),
        .set_done    (set_done),
        .set_err     (set_err),
        .clr_status  (clr_status),
        .start_pulse (start_pulse),
        .x0          (x0),
        .y0          (y0),
        .fill_w      (fill_w),
        .fill_h      (fill_h),
        .color       (color),
        .irq         (irq)
    );

    // Clipped end points in 11-bit arithmetic so origin+size cannot wrap.
    // The job registers are frozen while busy, so these stay valid for the
    // whole job without being latched.
    assign x_sum  = {1'b0, x0} + {1'b0, fill_w};
    assign y_sum  = {2'b00, y0} + {2'b00, fill_h};
    assign x_end  = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign y_clip = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign y_end  = y_clip[9:0];

    assign empty    = ({1'b0, x0} >= x_end) || ({1'b0, y0} >= y_end);
    assign start_go = start_pulse && !empty;
    assign busy     = (state != IDLE);

    assign x_next    = x + x_t'(TILE_W);
    assign y_next    = y + y_t'(TILE_H);
    assign row_wrap  = (x_next >= x_end);
    assign last_tile = row_wrap && (y_next >= y_end);
    assign xfer_done = (state == ACCESS) && m_pready;

    // Raster position: loaded on start, stepped after each good tile write,
    // returning to the left edge when the next tile would start past x_end.
    always_ff @(posedge clock) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (start_pulse) begin
            x <= {1'b0, x0};
            y <= {1'b0, y0};
        end else if (xfer_done && !m_pslverr) begin
            if (row_wrap) begin
                x <= {1'b0, x0};
                y <= y_next;
            end else begin
                x <= x_next;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: every tile gets its own SETUP phase; an error
    // response or the final tile returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_go) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (m_pready) begin
                    if (m_pslverr || last_tile) begin
                        state_next = IDLE;
                    end else begin
                        state_next = SETUP;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: master bus phases and the status pulses to the register file.
    // An empty rectangle reports done straight away without ever going busy.
    always_comb begin
        m_psel     = 1'b0;
        m_penable  = 1'b0;
        m_paddr    = '0;
        m_pwdata   = {4'h0, color, 4'h0, color};
        set_done   = 1'b0;
        set_err    = 1'b0;
        clr_status = start_go;

        if (state != IDLE) begin
            m_psel  = 1'b1;
            m_paddr = FB_BASE | {11'b0, x[9:0], 11'b0} | {21'b0, y[8:0], 2'b00};
        end
        if (state == ACCESS) begin
            m_penable = 1'b1;
        end

        if (start_pulse && empty) begin
            set_done = 1'b1;
        end
        if (xfer_done && (m_pslverr || last_tile)) begin
            set_done = 1'b1;
            set_err  = m_pslverr;
        end
    end

endmodule

// File: tb/tb_vga_fill_dma.sv
// Directed testbench for vga_fill_dma.
//
// Register programming goes through the APB slave; a passive monitor logs
// every completed master write so each scenario can compare the tile
// sequence against hand-computed addresses and data.

module tb_vga_fill_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_paddr = '0;
    logic        s_psel = 1'b0;
    logic        s_penable = 1'b0;
    logic        s_pwrite = 1'b0;
    logic [31:0] s_pwdata = '0;
    logic        s_pready;
    logic [31:0] s_prdata;
    logic        s_pslverr;
    logic [31:0] m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic [3:0]  m_pstrb;
    logic        m_pready = 1'b1;
    logic        m_pslverr = 1'b0;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] xfer_addr[$];
    logic [31:0] xfer_data[$];
    int          psel_cycles = 0;
    logic        b2b_seen = 1'b0;
    logic        last_completed = 1'b0;

    always #5 clock = ~clock;

    vga_fill_dma dut (
        .clock     (clock),
        .reset     (reset),
        .s_paddr   (s_paddr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_pwdata  (s_pwdata),
        .s_pready  (s_pready),
        .s_prdata  (s_prdata),
        .s_pslverr (s_pslverr),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .irq       (irq)
    );

    // Master-side monitor: logs completed writes, counts select cycles and
    // flags an ACCESS phase that directly follows a completed ACCESS.
    always @(posedge clock) begin
        if (m_psel && m_penable && last_completed) begin
            b2b_seen <= 1'b1;
        end
        if (m_psel) begin
            psel_cycles <= psel_cycles + 1;
        end
        if (m_psel && m_penable && m_pready) begin
            xfer_addr.push_back(m_paddr);
            xfer_data.push_back(m_pwdata);
        end
        last_completed <= m_psel && m_penable && m_pready;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        s_paddr   = addr;
        s_pwdata  = data;
        s_pwrite  = 1'b1;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(negedge clock);
        s_penable = 1'b1;
        @(posedge clock);
        #1;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        s_paddr   = addr;
        s_pwrite  = 1'b0;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        @(negedge clock);
        s_penable = 1'b1;
        data = s_prdata;
        @(posedge clock);
        #1;
        s_psel    = 1'b0;
        s_penable = 1'b0;
    endtask

    task automatic wait_irq(input int limit, output int cycles);
        cycles = 0;
        while (irq !== 1'b1 && cycles < limit) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1;
        tick(3);
        tests_run++;
        if (m_psel !== 1'b0 || m_penable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_master_phase: got psel=%b penable=%b expected 0 0", m_psel, m_penable);
        end
        tests_run++;
        if (m_paddr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_paddr: got %h expected 00000000", m_paddr);
        end
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_irq: got %b expected 0", irq);
        end
        tests_run++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b0 || m_pwrite !== 1'b1 || m_pstrb !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL reset_ties: got pready=%b pslverr=%b pwrite=%b pstrb=%h expected 1 0 1 f",
                     s_pready, s_pslverr, m_pwrite, m_pstrb);
        end
        reset = 1'b0;
        tick(1);
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", rd);
        end
        apb_read(32'h10, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_color: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_basic_fill;
        logic [31:0] exp_addr [4];
        logic [31:0] rd;
        logic [31:0] got;
        int base;
        int cycles;
        exp_addr[0] = 32'h2100_0000;
        exp_addr[1] = 32'h2100_3000;
        exp_addr[2] = 32'h2100_000C;
        exp_addr[3] = 32'h2100_300C;
        apb_write(32'h08, 32'h0000_0000);
        apb_write(32'h0C, 32'h0006_000C);
        apb_write(32'h10, 32'h0000_0F00);
        base = xfer_addr.size();
        apb_write(32'h00, 32'h3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_irq_at_start: got %b expected 0", irq);
        end
        wait_irq(50, cycles);
        tests_run++;
        if (cycles != 8) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", cycles);
        end
        tests_run++;
        if (xfer_addr.size() - base != 4) begin
            tests_failed++;
            $display("[TB] FAIL basic_tile_count: got %0d expected 4", xfer_addr.size() - base);
        end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < xfer_addr.size()) ? xfer_addr[base + i] : 32'hDEAD_DEAD;
            tests_run++;
            if (got !== exp_addr[i]) begin
                tests_failed++;
                $display("[TB] FAIL basic_addr_%0d: got %h expected %h", i, got, exp_addr[i]);
            end
            got = (base + i < xfer_data.size()) ? xfer_data[base + i] : 32'hDEAD_DEAD;
            tests_run++;
            if (got !== 32'h0F00_0F00) begin
                tests_failed++;
                $display("[TB] FAIL basic_data_%0d: got %h expected 0f000f00", i, got);
            end
        end
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL basic_status: got %h expected 00000002", rd);
        end
        apb_read(32'h00, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL basic_ctrl_read: got %h expected 00000002", rd);
        end
        apb_read(32'h14, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_empty;
        logic [31:0] rd;
        int base;
        apb_write(32'h04, 32'h6);
        apb_write(32'h0C, 32'h0006_0000);
        base = psel_cycles;
        apb_write(32'h00, 32'h3);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL empty_done_next_cycle: got irq=%b expected 1", irq);
        end
        tick(4);
        tests_run++;
        if (psel_cycles - base != 0) begin
            tests_failed++;
            $display("[TB] FAIL empty_no_psel: got %0d select cycles expected 0", psel_cycles - base);
        end
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL empty_status: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_clip;
        int base;
        int cycles;
        logic [31:0] got;
        apb_write(32'h04, 32'h6);
        apb_write(32'h10, 32'h0000_0ABC);
        apb_write(32'h08, 32'h01DE_027C);
        apb_write(32'h0C, 32'h0014_0014);
        base = xfer_addr.size();
        apb_write(32'h00, 32'h3);
        wait_irq(50, cycles);
        tests_run++;
        if (cycles != 2) begin
            tests_failed++;
            $display("[TB] FAIL clip_cycles: got %0d expected 2", cycles);
        end
        tests_run++;
        if (xfer_addr.size() - base != 1) begin
            tests_failed++;
            $display("[TB] FAIL clip_tile_count: got %0d expected 1", xfer_addr.size() - base);
        end
        got = (base < xfer_addr.size()) ? xfer_addr[base] : 32'hDEAD_DEAD;
        tests_run++;
        if (got !== 32'h2113_E778) begin
            tests_failed++;
            $display("[TB] FAIL clip_addr: got %h expected 2113e778", got);
        end
        got = (base < xfer_data.size()) ? xfer_data[base] : 32'hDEAD_DEAD;
        tests_run++;
        if (got !== 32'h0ABC_0ABC) begin
            tests_failed++;
            $display("[TB] FAIL clip_data: got %h expected 0abc0abc", got);
        end
    endtask

    task automatic test_stall;
        logic [31:0] rd;
        int base;
        apb_write(32'h04, 32'h6);
        apb_write(32'h08, 32'h0000_0000);
        apb_write(32'h0C, 32'h0006_000C);
        apb_write(32'h10, 32'h0000_0123);
        base = xfer_addr.size();
        m_pready = 1'b0;
        apb_write(32'h00, 32'h1);
        tests_run++;
        if (m_psel !== 1'b1 || m_penable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_setup: got psel=%b penable=%b expected 1 0", m_psel, m_penable);
        end
        tick(1);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (m_penable !== 1'b1 || m_paddr !== 32'h2100_0000 || m_pwdata !== 32'h0123_0123) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold_%0d: got penable=%b addr=%h data=%h expected 1 21000000 01230123",
                         k, m_penable, m_paddr, m_pwdata);
            end
            if (k < 2) tick(1);
        end
        m_pready = 1'b1;
        tick(1);
        tests_run++;
        if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_paddr !== 32'h2100_3000) begin
            tests_failed++;
            $display("[TB] FAIL stall_next_setup: got psel=%b penable=%b addr=%h expected 1 0 21003000",
                     m_psel, m_penable, m_paddr);
        end
        tick(10);
        tests_run++;
        if (xfer_addr.size() - base != 4) begin
            tests_failed++;
            $display("[TB] FAIL stall_tile_count: got %0d expected 4", xfer_addr.size() - base);
        end
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("[TB] FAIL stall_status: got %h expected 00000002", rd);
        end
        tests_run++;
        if (b2b_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_back_to_back_access: got %b expected 0", b2b_seen);
        end
    endtask

    task automatic test_slverr;
        logic [31:0] rd;
        int base;
        apb_write(32'h04, 32'h6);
        base = xfer_addr.size();
        apb_write(32'h00, 32'h1);
        tick(2);
        m_pslverr = 1'b1;
        tick(1);
        tests_run++;
        if (m_penable !== 1'b1 || m_paddr !== 32'h2100_3000) begin
            tests_failed++;
            $display("[TB] FAIL slverr_second_access: got penable=%b addr=%h expected 1 21003000", m_penable, m_paddr);
        end
        tick(1);
        m_pslverr = 1'b0;
        tests_run++;
        if (m_psel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL slverr_abort: got psel=%b expected 0", m_psel);
        end
        tick(5);
        tests_run++;
        if (xfer_addr.size() - base != 2) begin
            tests_failed++;
            $display("[TB] FAIL slverr_tile_count: got %0d expected 2", xfer_addr.size() - base);
        end
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h6) begin
            tests_failed++;
            $display("[TB] FAIL slverr_status: got %h expected 00000006", rd);
        end
        apb_write(32'h04, 32'h6);
        apb_read(32'h04, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL slverr_w1c: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_busy_lock;
        logic [31:0] rd;
        int base;
        int cycles;
        base = xfer_addr.size();
        apb_write(32'h00, 32'h3);
        apb_write(32'h0C, 32'h0000_0000);
        apb_write(32'h00, 32'h3);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_irq_early: got %b expected 0", irq);
        end
        wait_irq(50, cycles);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL busy_irq_rise: got %b expected 1", irq);
        end
        tick(4);
        tests_run++;
        if (xfer_addr.size() - base != 4) begin
            tests_failed++;
            $display("[TB] FAIL busy_start_ignored: got %0d tiles expected 4", xfer_addr.size() - base);
        end
        apb_read(32'h0C, rd);
        tests_run++;
        if (rd !== 32'h0006_000C) begin
            tests_failed++;
            $display("[TB] FAIL busy_size_locked: got %h expected 0006000c", rd);
        end
        apb_write(32'h04, 32'h2);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_irq_fall: got %b expected 0", irq);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        int base;
        base = xfer_addr.size();
        apb_write(32'h00, 32'h1);
        tick(3);
        reset = 1'b1;
        tick(1);
        tests_run++;
        if (m_psel !== 1'b0 || m_paddr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_drop: got psel=%b addr=%h expected 0 00000000", m_psel, m_paddr);
        end
        reset = 1'b0;
        tick(5);
        tests_run++;
        if (xfer_addr.size() - base != 2) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_discard: got %0d tiles expected 2", xfer_addr.size() - base);
        end
        apb_read(32'h0C, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_regs: got %h expected 00000000", rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_empty();
        test_clip();
        test_stall();
        test_slverr();
        test_busy_lock();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vga_fill_dma.md
Name: vga_fill_dma

Overview:
- Rectangle-fill engine directly upstream of the VGA framebuffer peripheral.
- The CPU programs origin, size and colour through an APB slave port.
- The engine then issues APB write bursts on its APB master port into the framebuffer window.
- Each master write paints one 6x3 pixel tile, so software writes 5 registers instead of one store per tile.

Parameters:
- FB_BASE, 32'h2100_0000, framebuffer APB base address; OR-ed with the tile offset.
- X_MAX, 640, exclusive horizontal clip limit (pixels).
- Y_MAX, 480, exclusive vertical clip limit (rows).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_paddr  in  32  slave address; bits [4:2] decoded
- s_psel  in  1  slave select
- s_penable  in  1  slave access phase
- s_pwrite  in  1  slave write
- s_pwdata  in  32  slave write data
- s_pready  out  1  tied 1
- s_prdata  out  32  register read data
- s_pslverr  out  1  tied 0
- m_paddr  out  32  master address
- m_psel  out  1  master select
- m_penable  out  1  master access phase
- m_pwrite  out  1  tied 1
- m_pwdata  out  32  {4'h0,color,4'h0,color}
- m_pstrb  out  4  tied 4'hF
- m_pready  in  1  framebuffer ready
- m_pslverr  in  1  framebuffer error
- irq  out  1  done & CTRL.ie

Behaviour:
- Clock and reset: clock is `clock`; reset is `reset`, synchronous, active-high.
- Reset values:
  - all registers 0; FSM IDLE.
  - m_psel=0, m_penable=0, m_paddr=0, irq=0.
  - A reset mid-transfer drops m_psel in the next cycle and discards the job.
- Register map (offset, fields). Reads return 0 for unmapped offsets. A write takes effect on s_psel & s_penable & s_pwrite.
  - 0x00 CTRL: [0] start (write-1 pulse, reads 0); [1] ie.
  - 0x04 STATUS: [0] busy (RO); [1] done (sticky, W1C); [2] err (sticky, W1C).
  - 0x08 ORIGIN: [9:0] x0, [24:16] y0.
  - 0x0C SIZE: [9:0] w, [24:16] h.
  - 0x10 COLOR: [11:0] color.
- While busy, writes to ORIGIN, SIZE, COLOR and CTRL.start are ignored; ie and STATUS W1C remain writable.
- Start:
  - Compute xend = min(x0+w, X_MAX) and yend = min(y0+h, Y_MAX) in 11-bit arithmetic (no wrap).
  - Set x=x0, y=y0.
  - If x0>=xend or y0>=yend: set done the next cycle, issue no transfers, busy never asserts.
  - Otherwise: clear done and err, set busy, enter SETUP.
- FSM states IDLE, SETUP, ACCESS:
  - SETUP: m_psel=1, m_penable=0. Drive m_paddr = FB_BASE | {x[9:0],11'b0} | {y[8:0],2'b0} and m_pwdata. Next state ACCESS.
  - ACCESS: m_psel=1, m_penable=1; address and data held stable. Stay while m_pready=0.
  - On m_pready=1 with m_pslverr=1: set err and done, clear busy, go IDLE (abort).
  - On m_pready=1 with m_pslverr=0, advance raster:
    - x += 6.
    - If x+6 >= xend (next x out of range): x = x0, y += 3.
    - If y+3 >= yend also holds: set done, clear busy, go IDLE.
    - Otherwise go SETUP.
- Throughput: 2 cycles per tile with m_pready tied 1; no back-to-back ACCESS without a SETUP.
- Tile count = ceil((xend-x0)/6) * ceil((yend-y0)/3). Partial edge tiles are written whole; the consumer clips.
- done asserts in the cycle after the final ACCESS completes. irq is combinational from done & ie.
- A W1C of done in the same cycle the engine sets done: set wins.

Decomposition:
- Package vga_pkg:
  - typedef fill_state_e {IDLE, SETUP, ACCESS}.
  - Register offset constants.
  - TILE_W=6, TILE_H=3.
  - x_t (logic [10:0]), y_t (logic [9:0]).
- Sub-module vga_fill_regs: the APB slave register file and CTRL/STATUS logic.
- The top module holds the raster counters and the master FSM.

Test Plan:
- ORIGIN=0, SIZE w=12 h=6, COLOR=12'hF00, start:
  - exactly 4 writes, in order, to 0x2100_0000, 0x2100_3000, 0x2100_000C, 0x2100_300C.
  - m_pwdata = 32'h0F00_0F00 on each.
  - done=1 after 8 busy cycles.
- SIZE w=0: start -> no m_psel, done=1 the next cycle, busy stays 0.
- ORIGIN x0=636 y0=478, w=20 h=20: xend=640, yend=480 -> a single write to 0x2100_0000 | (636<<11) | (478<<2).
- Hold m_pready=0 for 3 cycles in the first ACCESS: m_paddr/m_pwdata stable, m_penable held, the next SETUP only after pready.
- m_pslverr=1 on the 2nd transfer of a 4-tile job: err=1, done=1, busy=0, no 3rd transfer. Write STATUS 0x6 -> both cleared.
- While busy, write SIZE and start: ignored. With ie=1, irq rises with done and falls on W1C.
